rf_wb_arbiter: RTL

Register-file port controller for the 5-stage pipeline with multiple multicycle execution units. It decodes register-file read addresses from the F/D instruction and the sign-extend input from the D/X instruction. Each cycle it grants the single register-file write port to either the M/W instruction or one completed multicycle unit. A per-register busy scoreboard stalls F/D on hazards against in-flight multicycle results.

---
 rtl/rf_wb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file port controller: decodes read addresses, arbitrates the single write port
// between the M/W stage and multicycle units, and stalls F/D on hazards against in-flight results.
module rf_wb_arbiter #(
   parameter int NUM_MC = 2,
   parameter int DATA_W = 32,
   parameter int AW     = 5
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [31:0]              fd_ir,
   input  logic [31:0]              dx_ir,
   input  logic [31:0]              mw_ir,
   input  logic [DATA_W-1:0]        mw_data,
   input  logic [NUM_MC-1:0]        mc_issue,
   input  logic [NUM_MC-1:0]        mc_valid,
   input  logic [NUM_MC*DATA_W-1:0] mc_result,
   output logic [NUM_MC-1:0]        mc_ack,
   output logic [AW-1:0]            read_a,
   output logic [AW-1:0]            read_b,
   output logic [16:0]              sx_in,
   output logic                     rf_we,
   output logic [AW-1:0]            rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic                     stall_fd
);
   localparam int RW   = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
   localparam int NREG = 1 << AW;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [NUM_MC-1:0] pending;
   logic [AW-1:0]   dest [NUM_MC];
   logic [RW-1:0]   rr;
   logic [RW-1:0]   grant_idx;
   logic            grant_found;
   logic            mc_grant;
   logic            mw_wr;
   logic            mw_take;
   logic [4:0]      fd_op, mw_op, mw_alu;
   logic [AW-1:0]   fd_rd, fd_rs, fd_rt, dx_rd, mw_rd;
   logic            use_b, fd_writes;
   logic            unused_bits;

   assign fd_op  = fd_ir[31:27];
   assign fd_rd  = AW'(fd_ir[26:22]);
   assign fd_rs  = AW'(fd_ir[21:17]);
   assign fd_rt  = AW'(fd_ir[16:12]);
   assign dx_rd  = AW'(dx_ir[26:22]);
   assign mw_op  = mw_ir[31:27];
   assign mw_rd  = AW'(mw_ir[26:22]);
   assign mw_alu = mw_ir[6:2];
   assign sx_in  = dx_ir[16:0];
   assign unused_bits = ^{fd_ir[11:0], dx_ir[31:27], dx_ir[21:17], mw_ir[21:7], mw_ir[1:0]};

   // Branches compare rd against rs; loads/stores put the base in rs and data in rd.
   always_comb begin
      read_a = fd_rs;
      read_b = fd_rt;
      if (fd_op == 5'd2 || fd_op == 5'd6) begin
         read_a = fd_rd;
         read_b = fd_rs;
      end else if (fd_op == 5'd7 || fd_op == 5'd8) begin
         read_a = fd_rs;
         read_b = fd_rd;
      end
   end

   assign use_b     = (fd_op == 5'd0) || (fd_op == 5'd2) || (fd_op == 5'd6) || (fd_op == 5'd7);
   assign fd_writes = (fd_op == 5'd0) || (fd_op == 5'd5) || (fd_op == 5'd8);

   assign stall_fd = ((read_a != '0) && busy[read_a])
                   || (use_b && (read_b != '0) && busy[read_b])
                   || (fd_writes && (fd_rd != '0) && busy[fd_rd]);

   // Mult/div ALU ops (aluop 6,7) retire through their unit, not through M/W.
   assign mw_wr   = ((mw_op == 5'd0) && (mw_alu != 5'd6) && (mw_alu != 5'd7))
                  || (mw_op == 5'd5) || (mw_op == 5'd8);
   assign mw_take = mw_wr && (mw_rd != '0);

   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = 0; k < NUM_MC; k++) begin
         idx = int'(rr) + k;
         if (idx >= NUM_MC) idx = idx - NUM_MC;
         if (!grant_found && mc_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = RW'(idx);
         end
      end
   end

   assign mc_grant = grant_found && !mw_take && reset_n;

   always_comb begin
      mc_ack   = '0;
      rf_we    = 1'b0;
      rf_waddr = mw_rd;
      rf_wdata = mw_data;
      if (mw_take) begin
         rf_we = reset_n;
      end else if (mc_grant) begin
         mc_ack[grant_idx] = 1'b1;
         rf_we    = (dest[grant_idx] != '0);
         rf_waddr = dest[grant_idx];
         rf_wdata = mc_result[grant_idx*DATA_W +: DATA_W];
      end
   end

   // Clear before set so an issue to the same register in the same cycle keeps it busy.
   always_comb begin
      busy_nxt = busy;
      if (mc_grant) busy_nxt[dest[grant_idx]] = 1'b0;
      if ((|mc_issue) && (dx_rd != '0)) busy_nxt[dx_rd] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy    <= '0;
         pending <= '0;
         rr      <= '0;
         for (int i = 0; i < NUM_MC; i++) dest[i] <= '0;
      end else begin
         busy <= busy_nxt;
         if (mc_grant) begin
            pending[grant_idx] <= 1'b0;
            rr <= (int'(grant_idx) == NUM_MC - 1) ? '0 : grant_idx + 1'b1;
         end
         for (int i = 0; i < NUM_MC; i++) begin
            if (mc_issue[i] && !pending[i]) begin
               dest[i]    <= dx_rd;
               pending[i] <= 1'b1;
            end
         end
      end
   end
endmodule
